// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: bundle between N_PORTS request FIFOs, the port arbiter and the SDRAM
// command sequencer.
//   PORT_WRITE_IN / PORT_ACS_IN / PORT_RCHG_IN / PORT_REQ_IN : per-port FIFO head (dir, access, row change, valid)
//   PORT_ACK_OUT                                             : per-port pop
//   MEM_WRITE_OUT / MEM_ACS_OUT / MEM_RCHG_OUT / MEM_REQ_OUT : muxed request to the sequencer
//   MEM_ACK_IN                                               : sequencer accept
//   MEM_PORT_OUT                                             : index of the granted port (read data routing)
//   REF_REQ_IN / REF_GNT_OUT                                 : refresh request / bus released for refresh
// The access word is the packed dram_access_t {bank, row, col, data}; the arbiter only muxes it, so
// it is carried as an opaque ACS_W-bit vector.
// Modports: master = arbiter side, slave = port FIFOs plus sequencer side.
interface sdram_port_arbiter_if #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ACS_W   = 41
);
    localparam int unsigned PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0]            PORT_WRITE_IN;
    logic [N_PORTS-1:0][ACS_W-1:0] PORT_ACS_IN;
    logic [N_PORTS-1:0]            PORT_RCHG_IN;
    logic [N_PORTS-1:0]            PORT_REQ_IN;
    logic [N_PORTS-1:0]            PORT_ACK_OUT;
    logic                          MEM_WRITE_OUT;
    logic [ACS_W-1:0]              MEM_ACS_OUT;
    logic                          MEM_RCHG_OUT;
    logic                          MEM_REQ_OUT;
    logic                          MEM_ACK_IN;
    logic [PORT_W-1:0]             MEM_PORT_OUT;
    logic                          REF_REQ_IN;
    logic                          REF_GNT_OUT;

    modport master (
        input  PORT_WRITE_IN, PORT_ACS_IN, PORT_RCHG_IN, PORT_REQ_IN, MEM_ACK_IN, REF_REQ_IN,
        output PORT_ACK_OUT, MEM_WRITE_OUT, MEM_ACS_OUT, MEM_RCHG_OUT, MEM_REQ_OUT, MEM_PORT_OUT,
               REF_GNT_OUT
    );

    modport slave (
        output PORT_WRITE_IN, PORT_ACS_IN, PORT_RCHG_IN, PORT_REQ_IN, MEM_ACK_IN, REF_REQ_IN,
        input  PORT_ACK_OUT, MEM_WRITE_OUT, MEM_ACS_OUT, MEM_RCHG_OUT, MEM_REQ_OUT, MEM_PORT_OUT,
               REF_GNT_OUT
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM command sequencer between N_PORTS buffered request streams.
// Each grant is a burst of up to N_BURSTS accepted beats from one port, chosen round-robin after a
// one-cycle arbitration bubble in IDLE. Refresh is granted only from IDLE, i.e. between bursts.
// Ports:
//   CLK       system clock (posedge)
//   RESET_IN  synchronous active-high reset
//   bus       sdram_port_arbiter_if.master (port FIFO heads, sequencer handshake, refresh)
// Optional feature: define SDRAM_ARB_ROW_HIT_EN to regrant the previous port (up to MAX_HITS times
// in a row) while its next access stays in the open row.
module sdram_port_arbiter #(
    parameter int unsigned N_PORTS  = 4,
    parameter int unsigned N_BURSTS = 8,
    parameter int unsigned MAX_HITS = 4,
    parameter int unsigned ACS_W    = 41
) (
    input logic                  CLK,
    input logic                  RESET_IN,
    sdram_port_arbiter_if.master bus
);
    localparam int unsigned PORT_W = $clog2(N_PORTS);
    localparam int unsigned BEAT_W = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;

    if (N_PORTS < 2 || N_BURSTS < 1 || MAX_HITS < 1) begin : g_bad_params
        $error("sdram_port_arbiter: illegal parameters");
    end

    typedef enum logic [1:0] {StIdle, StBurst, StRefresh} state_e;

    state_e            state_q, state_d;
    logic [PORT_W-1:0] gnt_q, gnt_d;
    logic [PORT_W-1:0] last_q, last_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              dir_q, dir_d;         // direction of beat 0 of the current grant
    logic              regrant_q, regrant_d; // current grant is a row-hit regrant

`ifdef SDRAM_ARB_ROW_HIT_EN
    localparam int unsigned HIT_W = $clog2(MAX_HITS + 1);
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             row_hit;
`endif

    logic              g_req, g_write, g_rchg;
    logic              split, mem_req, beat;
    logic [31:0]       cand;
    logic [PORT_W-1:0] cand_idx, rr_idx;
    logic              rr_found;

    assign g_req   = bus.PORT_REQ_IN[gnt_q];
    assign g_write = bus.PORT_WRITE_IN[gnt_q];
    assign g_rchg  = bus.PORT_RCHG_IN[gnt_q];

    // Past beat 0 a direction flip or row change ends the grant; that access waits in its FIFO.
    assign split = (beat_cnt_q != '0) && ((g_write != dir_q) || g_rchg);

    // Round-robin: first requester after the last granted port.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand     = (32'(last_q) + i) % N_PORTS;
            cand_idx = cand[PORT_W-1:0];
            if (!rr_found && bus.PORT_REQ_IN[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

`ifdef SDRAM_ARB_ROW_HIT_EN
    assign row_hit = bus.PORT_REQ_IN[last_q] && !bus.PORT_RCHG_IN[last_q] &&
                     (hit_cnt_q < HIT_W'(MAX_HITS));
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        dir_d      = dir_q;
        regrant_d  = regrant_q;
`ifdef SDRAM_ARB_ROW_HIT_EN
        hit_cnt_d  = hit_cnt_q;
`endif
        mem_req           = 1'b0;
        beat              = 1'b0;
        bus.PORT_ACK_OUT  = '0;
        bus.MEM_REQ_OUT   = 1'b0;
        bus.MEM_RCHG_OUT  = 1'b0;
        bus.REF_GNT_OUT   = 1'b0;
        bus.MEM_WRITE_OUT = g_write;
        bus.MEM_ACS_OUT   = bus.PORT_ACS_IN[gnt_q];
        bus.MEM_PORT_OUT  = gnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.REF_REQ_IN) begin
                    state_d = StRefresh;
`ifdef SDRAM_ARB_ROW_HIT_EN
                end else if (row_hit) begin
                    state_d    = StBurst;
                    gnt_d      = last_q;
                    beat_cnt_d = '0;
                    regrant_d  = 1'b1;
                    hit_cnt_d  = hit_cnt_q + 1'b1;
`endif
                end else if (rr_found) begin
                    state_d    = StBurst;
                    gnt_d      = rr_idx;
                    last_d     = rr_idx;
                    beat_cnt_d = '0;
                    regrant_d  = 1'b0;
`ifdef SDRAM_ARB_ROW_HIT_EN
                    hit_cnt_d  = '0;
`endif
                end
            end
            StBurst: begin
                mem_req                 = g_req && !split;
                beat                    = mem_req && bus.MEM_ACK_IN;
                bus.MEM_REQ_OUT         = mem_req;
                bus.PORT_ACK_OUT[gnt_q] = beat;
                // A fresh grant may follow another port, so the sequencer must re-open the row.
                bus.MEM_RCHG_OUT        = g_rchg || ((beat_cnt_q == '0) && !regrant_q);
                if (!g_req || split) begin
                    state_d = StIdle;
                end else if (beat) begin
                    if (beat_cnt_q == '0) begin
                        dir_d = g_write;
                    end
                    if (beat_cnt_q == BEAT_W'(N_BURSTS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StRefresh: begin
                bus.REF_GNT_OUT = bus.REF_REQ_IN;
                if (!bus.REF_REQ_IN) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET_IN) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            last_q     <= PORT_W'(N_PORTS - 1);
            beat_cnt_q <= '0;
            dir_q      <= 1'b0;
            regrant_q  <= 1'b0;
`ifdef SDRAM_ARB_ROW_HIT_EN
            hit_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            dir_q      <= dir_d;
            regrant_q  <= regrant_d;
`ifdef SDRAM_ARB_ROW_HIT_EN
            hit_cnt_q  <= hit_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
    localparam int N  = 4;
    localparam int NB = 8;
    localparam int MH = 4;
    localparam int AW = 41;

    logic CLK = 1'b0;
    logic RESET_IN;
    always #5 CLK = ~CLK;

    sdram_port_arbiter_if #(.N_PORTS(N), .ACS_W(AW)) bus ();

    sdram_port_arbiter #(
        .N_PORTS (N),
        .N_BURSTS(NB),
        .MAX_HITS(MH),
        .ACS_W   (AW)
    ) dut (
        .CLK     (CLK),
        .RESET_IN(RESET_IN),
        .bus     (bus)
    );

    // Port FIFOs: entry = {write, rchg, access}
    logic [AW+1:0] fifo [N][$];
    int ack_cnt [N];
    int ack_log [$];
    int rchg_log [$];
    int ref_cycles;
    int checks   = 0;
    int failures = 0;

    // Stimulus knobs
    int ack_mode  = 1;   // 0 random, 1 always, 2 never
    bit rand_mode = 0;
    bit ref_req   = 0;

    // Reference model: who owns the sequencer and how far its burst has got
    localparam int OWN_IDLE = -1;
    localparam int OWN_REF  = -2;
    int owner, m_gnt, m_last, m_beats, m_hits;
    bit m_dir, m_regrant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW+1:0] mk_entry(input bit wr, input bit rc);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {wr, rc, r[AW-1:0]};
    endfunction

    task automatic model_reset();
        owner = OWN_IDLE; m_gnt = 0; m_last = N - 1; m_beats = 0; m_hits = 0;
        m_dir = 0; m_regrant = 0;
    endtask

    task automatic clear_logs();
        for (int p = 0; p < N; p++) ack_cnt[p] = 0;
        ack_log.delete();
        rchg_log.delete();
        ref_cycles = 0;
    endtask

    task automatic drive();
        logic [AW+1:0] e;
        if (rand_mode) begin
            int p;
            p = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) == 0 && fifo[p].size() < 6)
                fifo[p].push_back(mk_entry($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0));
            if (!ref_req && $urandom_range(0, 39) == 0) ref_req = 1;
            else if (ref_req && $urandom_range(0, 7) == 0) ref_req = 0;
        end
        for (int p = 0; p < N; p++) begin
            if (fifo[p].size() > 0) begin
                e = fifo[p][0];
                bus.PORT_REQ_IN[p] = 1'b1;
            end else begin
                e = mk_entry($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                bus.PORT_REQ_IN[p] = 1'b0;
            end
            bus.PORT_WRITE_IN[p] = e[AW+1];
            bus.PORT_RCHG_IN[p]  = e[AW];
            bus.PORT_ACS_IN[p]   = e[AW-1:0];
        end
        bus.MEM_ACK_IN = (ack_mode == 0) ? ($urandom_range(0, 3) != 0) : (ack_mode == 1);
        bus.REF_REQ_IN = ref_req;
    endtask

    // One clock: drive, compare against the model, advance the model, pop accepted accesses.
    task automatic step();
        logic         exp_req, exp_rchg, exp_ref, pending, split, granted;
        logic [N-1:0] exp_ack;
        int           g, p;
        drive();
        #1;
        exp_req = 0; exp_rchg = 0; exp_ref = 0; exp_ack = '0; pending = 0; split = 0;
        g = m_gnt;
        if (owner >= 0) begin
            pending    = bus.PORT_REQ_IN[g];
            split      = (m_beats > 0) && ((bus.PORT_WRITE_IN[g] != m_dir) || bus.PORT_RCHG_IN[g]);
            exp_req    = pending && !split;
            exp_ack[g] = exp_req && bus.MEM_ACK_IN;
            exp_rchg   = bus.PORT_RCHG_IN[g] || (m_beats == 0 && !m_regrant);
            chk("mem_write", 64'(bus.MEM_WRITE_OUT), 64'(bus.PORT_WRITE_IN[g]));
            chk("mem_acs", 64'(bus.MEM_ACS_OUT), 64'(bus.PORT_ACS_IN[g]));
            chk("mem_rchg", 64'(bus.MEM_RCHG_OUT), 64'(exp_rchg));
        end else if (owner == OWN_REF) begin
            exp_ref = bus.REF_REQ_IN;
        end
        chk("mem_req", 64'(bus.MEM_REQ_OUT), 64'(exp_req));
        chk("port_ack", 64'(bus.PORT_ACK_OUT), 64'(exp_ack));
        chk("ref_gnt", 64'(bus.REF_GNT_OUT), 64'(exp_ref));
        chk("mem_port", 64'(bus.MEM_PORT_OUT), 64'(m_gnt));
        if (bus.REF_GNT_OUT === 1'b1) ref_cycles++;

        if (exp_ack[g]) begin
            void'(fifo[g].pop_front());
            ack_cnt[g]++;
            ack_log.push_back(g);
            rchg_log.push_back(int'(exp_rchg));
        end

        if (RESET_IN) begin
            model_reset();
        end else if (owner == OWN_IDLE) begin
            granted = 0;
            if (bus.REF_REQ_IN) begin
                owner   = OWN_REF;
                granted = 1;
            end
`ifdef SDRAM_ARB_ROW_HIT_EN
            if (!granted && bus.PORT_REQ_IN[m_last] && !bus.PORT_RCHG_IN[m_last] && m_hits < MH) begin
                owner = m_last; m_gnt = m_last; m_beats = 0; m_regrant = 1; m_hits++;
                granted = 1;
            end
`endif
            for (int k = 1; k <= N; k++) begin
                p = (m_last + k) % N;
                if (!granted && bus.PORT_REQ_IN[p]) begin
                    owner = p; m_gnt = p; m_last = p; m_beats = 0; m_regrant = 0; m_hits = 0;
                    granted = 1;
                end
            end
        end else if (owner == OWN_REF) begin
            if (!bus.REF_REQ_IN) owner = OWN_IDLE;
        end else begin
            if (!pending || split) begin
                owner = OWN_IDLE;
            end else if (exp_ack[g]) begin
                if (m_beats == 0) m_dir = bus.PORT_WRITE_IN[g];
                m_beats++;
                if (m_beats == NB) owner = OWN_IDLE;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int left;
        for (int i = 0; i < 400; i++) begin
            left = 0;
            for (int p = 0; p < N; p++) left += fifo[p].size();
            if (left == 0) break;
            step();
        end
        left = 0;
        for (int p = 0; p < N; p++) left += fifo[p].size();
        chk("drain", 64'(left), 64'd0);
        run(3);
    endtask

    task automatic do_reset();
        RESET_IN = 1'b1;
        run(2);
        RESET_IN = 1'b0;
    endtask

    initial begin
        RESET_IN = 1'b1;
        bus.PORT_REQ_IN = '0; bus.PORT_WRITE_IN = '0; bus.PORT_RCHG_IN = '0; bus.PORT_ACS_IN = '0;
        bus.MEM_ACK_IN = 1'b0; bus.REF_REQ_IN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        model_reset();
        RESET_IN = 1'b0;
        clear_logs();
        run(2);   // reset state: all outputs idle, MEM_PORT_OUT=0

        // All four ports busy, sequencer always ready: 0,1,2,3,0 with 8 beats each
        clear_logs();
        for (int p = 0; p < N; p++)
            for (int i = 0; i < 16; i++) fifo[p].push_back(mk_entry(1, 0));
        run(45);
        chk("rr_acks0", 64'(ack_cnt[0]), 64'd16);
        for (int p = 1; p < N; p++) chk("rr_acks", 64'(ack_cnt[p]), 64'd8);
        for (int k = 0; k < 5; k++) chk("rr_order", 64'(ack_log[8 * k]), 64'(k % N));
        drain();

        // Single port, three reads: three acks, row change only on beat 0
        clear_logs();
        for (int i = 0; i < 3; i++) fifo[2].push_back(mk_entry(0, 0));
        run(10);
        chk("p2_acks", 64'(ack_cnt[2]), 64'd3);
        chk("p2_rchg0", 64'(rchg_log[0]), 64'd1);
        chk("p2_rchg1", 64'(rchg_log[1]), 64'd0);
        chk("p2_rchg2", 64'(rchg_log[2]), 64'd0);

        // Refresh raised at beat 3 of a port 1 burst
        clear_logs();
        for (int i = 0; i < 8; i++) fifo[1].push_back(mk_entry(1, 0));
        run(4);
        ref_req = 1;
        fifo[2].push_back(mk_entry(0, 0));
        fifo[2].push_back(mk_entry(0, 0));
        run(10);
        chk("ref_p1_acks", 64'(ack_cnt[1]), 64'd8);
        chk("ref_p2_held", 64'(ack_cnt[2]), 64'd0);
        chk("ref_cycles", 64'(ref_cycles), 64'd4);
        ref_req = 0;
        run(6);
        chk("ref_p2_after", 64'(ack_cnt[2]), 64'd2);

        // Port 0 write then read: the read waits for a later grant, port 1 goes in between
        clear_logs();
        fifo[0].push_back(mk_entry(1, 0));
        fifo[0].push_back(mk_entry(0, 0));
        fifo[1].push_back(mk_entry(1, 0));
        run(10);
        chk("dir_log_len", 64'(ack_log.size()), 64'd3);
        chk("dir_order0", 64'(ack_log[0]), 64'd0);
        chk("dir_order1", 64'(ack_log[1]), 64'd1);
        chk("dir_order2", 64'(ack_log[2]), 64'd0);

        // Sequencer stalled for 20 cycles inside a burst
        clear_logs();
        ack_mode = 2;
        fifo[3].push_back(mk_entry(1, 0));
        fifo[3].push_back(mk_entry(1, 0));
        run(21);
        chk("stall_acks", 64'(ack_cnt[3]), 64'd0);
        chk("stall_req", 64'(bus.MEM_REQ_OUT), 64'd1);
        chk("stall_port", 64'(bus.MEM_PORT_OUT), 64'd3);
        ack_mode = 1;
        drain();

`ifdef SDRAM_ARB_ROW_HIT_EN
        // Row hits: port 0 kept for 1 + MAX_HITS grants before port 1
        do_reset();
        clear_logs();
        for (int i = 0; i < 48; i++) fifo[0].push_back(mk_entry(1, 0));
        for (int i = 0; i < 8; i++) fifo[1].push_back(mk_entry(1, 0));
        run(50);
        chk("hit_p0", 64'(ack_log[NB * (MH + 1) - 1]), 64'd0);
        chk("hit_p1", 64'(ack_log[NB * (MH + 1)]), 64'd1);
        drain();
`endif

        // Random traffic with random sequencer stalls, refreshes and a reset mid-run
        clear_logs();
        ack_mode  = 0;
        rand_mode = 1;
        run(400);
        RESET_IN = 1'b1;
        step();
        RESET_IN = 1'b0;
        run(400);
        rand_mode = 0;
        ref_req   = 0;
        ack_mode  = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
